// File: rtl/x4xx_version_table_pkg.sv
// Shared constants and types for the x4xx version table.
// Field layout, register offsets, ctrlport status codes and FSM encoding.
package x4xx_version_table_pkg;

   localparam int VERSION_W             = 32;
   localparam int TIMESTAMP_W           = 32;
   localparam int SLOT_W                = 2*VERSION_W + TIMESTAMP_W;
   localparam int MAJOR_MSB             = 31;
   localparam int MAJOR_LSB             = 23;
   localparam int MAX_NUM_OF_COMPONENTS = 64;

   localparam int CTRLPORT_ADDR_W = 20;
   localparam int CTRLPORT_DATA_W = 32;
   localparam logic [19:0] WINDOW_BYTES = 20'h400;

   localparam logic [3:0] OFFS_CURRENT           = 4'h0;
   localparam logic [3:0] OFFS_OLDEST_COMPATIBLE = 4'h4;
   localparam logic [3:0] OFFS_LAST_MODIFIED     = 4'h8;
   localparam logic [3:0] OFFS_COMPAT_CHECK      = 4'hC;

   localparam logic [1:0] STS_OKAY    = 2'd0;
   localparam logic [1:0] STS_CMDERR  = 2'd1;
   localparam logic [1:0] STS_TSERR   = 2'd2;
   localparam logic [1:0] STS_WARNING = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Bit order matches the COMPAT_CHECK readback layout.
   typedef struct packed {
      logic too_new;
      logic too_old;
      logic checked;
   } compat_flags_t;

endpackage

// File: rtl/x4xx_version_table_if.sv
// Ctrlport request/response bundle for the version table.
interface x4xx_version_table_if;

   logic                                                 req_wr;
   logic                                                 req_rd;
   logic [x4xx_version_table_pkg::CTRLPORT_ADDR_W-1:0]   req_addr;
   logic [x4xx_version_table_pkg::CTRLPORT_DATA_W-1:0]   req_data;
   logic                                                 resp_ack;
   logic [1:0]                                           resp_status;
   logic [x4xx_version_table_pkg::CTRLPORT_DATA_W-1:0]   resp_data;

   modport master (
      output req_wr, req_rd, req_addr, req_data,
      input  resp_ack, resp_status, resp_data
   );

   modport slave (
      input  req_wr, req_rd, req_addr, req_data,
      output resp_ack, resp_status, resp_data
   );

endinterface

// File: rtl/x4xx_version_compat_cmp.sv
// Software-vs-component compatibility compare (purely combinational).
module x4xx_version_compat_cmp
   import x4xx_version_table_pkg::*;
(
   input  logic [VERSION_W-1:0] current_ver,
   input  logic [VERSION_W-1:0] oldest_ver,
   input  logic [VERSION_W-1:0] sw_ver,
   output logic                 too_old,
   output logic                 too_new
);

   // Component is too old when its major field trails the software's.
   assign too_old = current_ver[MAJOR_MSB:MAJOR_LSB] < sw_ver[MAJOR_MSB:MAJOR_LSB];
   assign too_new = sw_ver < oldest_ver;

endmodule

// File: rtl/x4xx_version_table.sv
// Ctrlport-mapped component version table with optional compatibility check.
// Compat storage and compat_error exist only with X4XX_VERSION_COMPAT_CHECK_EN.
//
// state     | meaning
// ST_IDLE   | waiting for a request; latches addr/data/type
// ST_DECODE | decodes latched request, loads response registers
// ST_RESP   | resp_ack high for this single cycle
module x4xx_version_table
   import x4xx_version_table_pkg::*;
#(
   parameter int REG_BASE       = 0,
   parameter int NUM_COMPONENTS = 64
) (
   input  logic                             s_ctrlport_clk,
   input  logic                             s_ctrlport_rst_n,
   x4xx_version_table_if.slave              s_ctrlport,
   input  logic [NUM_COMPONENTS*SLOT_W-1:0] version_info,
   output logic                             compat_error
);

   localparam logic [19:0] BASE_ADDR = 20'(REG_BASE);
   localparam logic [6:0]  NUM_COMP  = 7'(NUM_COMPONENTS);

   state_t      state_q, state_d;
   logic        is_wr_q, is_wr_d;
   logic [19:0] addr_q, addr_d;
   logic        resp_ack_q, resp_ack_d;
   logic [1:0]  resp_status_q, resp_status_d;
   logic [31:0] resp_data_q, resp_data_d;

   logic [19:0]       offs;
   logic              in_win;
   logic [5:0]        slot;
   logic              slot_valid;
   logic [3:0]        reg_offs;
   logic [SLOT_W-1:0] slot_info;

   always_comb begin
      offs       = addr_q - BASE_ADDR;
      in_win     = (addr_q >= BASE_ADDR) && (offs < WINDOW_BYTES);
      slot       = offs[9:4];
      reg_offs   = {offs[3:2], 2'b00};
      slot_valid = {1'b0, slot} < NUM_COMP;
      slot_info  = '0;
      for (int k = 0; k < NUM_COMPONENTS; k++) begin
         if (slot == 6'(k)) slot_info = version_info[k*SLOT_W +: SLOT_W];
      end
   end

`ifdef X4XX_VERSION_COMPAT_CHECK_EN
   logic [31:0]   data_q, data_d;
   compat_flags_t flags_q [MAX_NUM_OF_COMPONENTS];
   compat_flags_t flags_d [MAX_NUM_OF_COMPONENTS];
   logic          compat_error_q, compat_error_d;
   logic          too_old, too_new;

   x4xx_version_compat_cmp u_cmp (
      .current_ver (slot_info[VERSION_W-1:0]),
      .oldest_ver  (slot_info[2*VERSION_W-1:VERSION_W]),
      .sw_ver      (data_q),
      .too_old     (too_old),
      .too_new     (too_new)
   );

   always_comb begin
      compat_error_d = 1'b0;
      for (int k = 0; k < NUM_COMPONENTS; k++) begin
         compat_error_d = compat_error_d | flags_d[k].too_old | flags_d[k].too_new;
      end
   end

   always_ff @(posedge s_ctrlport_clk or negedge s_ctrlport_rst_n) begin
      if (!s_ctrlport_rst_n) begin
         data_q         <= '0;
         compat_error_q <= 1'b0;
         for (int k = 0; k < MAX_NUM_OF_COMPONENTS; k++) flags_q[k] <= '0;
      end else begin
         data_q         <= data_d;
         compat_error_q <= compat_error_d;
         for (int k = 0; k < MAX_NUM_OF_COMPONENTS; k++) flags_q[k] <= flags_d[k];
      end
   end

   assign compat_error = compat_error_q;
`else
   assign compat_error = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      is_wr_d       = is_wr_q;
      addr_d        = addr_q;
      resp_ack_d    = 1'b0;
      resp_status_d = resp_status_q;
      resp_data_d   = resp_data_q;
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
      data_d  = data_q;
      flags_d = flags_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (s_ctrlport.req_wr || s_ctrlport.req_rd) begin
               is_wr_d = s_ctrlport.req_wr;
               addr_d  = s_ctrlport.req_addr;
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
               data_d  = s_ctrlport.req_data;
`endif
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (!in_win) begin
               state_d = ST_IDLE;
            end else begin
               state_d       = ST_RESP;
               resp_ack_d    = 1'b1;
               resp_status_d = STS_CMDERR;
               resp_data_d   = '0;
               if (slot_valid) begin
                  case (reg_offs)
                     OFFS_CURRENT: if (!is_wr_q) begin
                        resp_status_d = STS_OKAY;
                        resp_data_d   = slot_info[VERSION_W-1:0];
                     end
                     OFFS_OLDEST_COMPATIBLE: if (!is_wr_q) begin
                        resp_status_d = STS_OKAY;
                        resp_data_d   = slot_info[2*VERSION_W-1:VERSION_W];
                     end
                     OFFS_LAST_MODIFIED: if (!is_wr_q) begin
                        resp_status_d = STS_OKAY;
                        resp_data_d   = slot_info[SLOT_W-1:2*VERSION_W];
                     end
                     default: begin
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
                        resp_status_d = STS_OKAY;
                        if (is_wr_q) flags_d[slot] = {too_new, too_old, 1'b1};
                        else         resp_data_d   = 32'(flags_q[slot]);
`else
                        if (!is_wr_q) resp_status_d = STS_OKAY;
`endif
                     end
                  endcase
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge s_ctrlport_clk or negedge s_ctrlport_rst_n) begin
      if (!s_ctrlport_rst_n) begin
         state_q       <= ST_IDLE;
         is_wr_q       <= 1'b0;
         addr_q        <= '0;
         resp_ack_q    <= 1'b0;
         resp_status_q <= STS_OKAY;
         resp_data_q   <= '0;
      end else begin
         state_q       <= state_d;
         is_wr_q       <= is_wr_d;
         addr_q        <= addr_d;
         resp_ack_q    <= resp_ack_d;
         resp_status_q <= resp_status_d;
         resp_data_q   <= resp_data_d;
      end
   end

   assign s_ctrlport.resp_ack    = resp_ack_q;
   assign s_ctrlport.resp_status = resp_status_q;
   assign s_ctrlport.resp_data   = resp_data_q;

endmodule

// File: tb/tb_x4xx_version_table.sv
// Bench for x4xx_version_table: directed cases plus random accesses against a table model.
module tb_x4xx_version_table;

   localparam int REG_BASE = 'h1000;
   localparam int NCOMP    = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic [NCOMP*96-1:0] version_info;
   logic compat_error;

   x4xx_version_table_if bus ();

   x4xx_version_table #(.REG_BASE(REG_BASE), .NUM_COMPONENTS(NCOMP)) dut (
      .s_ctrlport_clk   (clk),
      .s_ctrlport_rst_n (rst_n),
      .s_ctrlport       (bus),
      .version_info     (version_info),
      .compat_error     (compat_error)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] cur_m [NCOMP];
   logic [31:0] old_m [NCOMP];
   logic [31:0] ts_m  [NCOMP];
   int          flag_m [64];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply_versions();
      for (int k = 0; k < NCOMP; k++) version_info[k*96 +: 96] = {ts_m[k], old_m[k], cur_m[k]};
   endtask

   function automatic logic model_cerr();
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
      for (int k = 0; k < NCOMP; k++) if (flag_m[k] > 1) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Expected response per the register map; updates model flags on check writes.
   task automatic model(input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                        output logic e_ack, output logic [1:0] e_sts, output logic [31:0] e_data);
      int off, slot, sel;
      e_ack = 1'b0; e_sts = 2'd0; e_data = 32'd0;
      if (int'(addr) < REG_BASE || int'(addr) >= REG_BASE + 1024) return;
      off = int'(addr) - REG_BASE;
      slot = off / 16;
      sel = (off % 16) / 4;
      e_ack = 1'b1; e_sts = 2'd1;
      if (slot >= NCOMP) return;
      if (sel < 3) begin
         if (!wr) begin
            e_sts = 2'd0;
            e_data = (sel == 0) ? cur_m[slot] : (sel == 1) ? old_m[slot] : ts_m[slot];
         end
         return;
      end
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
      e_sts = 2'd0;
      if (wr) flag_m[slot] = 1 + (((cur_m[slot] >> 23) < (wdata >> 23)) ? 2 : 0)
                               + ((wdata < old_m[slot]) ? 4 : 0);
      else    e_data = 32'(flag_m[slot]);
`else
      if (!wr) e_sts = 2'd0;
`endif
   endtask

   // Issues one request and watches 10 cycles; called just after a rising edge.
   task automatic access(input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                         output int acks, output int lat, output logic [1:0] sts, output logic [31:0] rd);
      acks = 0; lat = 0; sts = 2'd0; rd = 32'd0;
      bus.req_wr = wr; bus.req_rd = !wr; bus.req_addr = addr; bus.req_data = wdata;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         bus.req_wr = 1'b0; bus.req_rd = 1'b0;
         if (bus.resp_ack === 1'b1) begin
            if (acks == 0) begin lat = c; sts = bus.resp_status; rd = bus.resp_data; end
            acks++;
         end
      end
   endtask

   task automatic run(input string tag, input logic wr, input logic [19:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rd);
      logic e_ack; logic [1:0] e_sts; logic [31:0] e_data;
      logic [1:0] sts; int acks, lat;
      model(wr, addr, wdata, e_ack, e_sts, e_data);
      access(wr, addr, wdata, acks, lat, sts, rd);
      check({tag, ".acks"}, 32'(acks), e_ack ? 32'd1 : 32'd0);
      if (e_ack) begin
         check({tag, ".lat"}, 32'(lat), 32'd2);
         check({tag, ".sts"}, 32'(sts), 32'(e_sts));
         check({tag, ".sts_hold"}, 32'(bus.resp_status), 32'(e_sts));
         if (!wr) begin
            check({tag, ".data"}, rd, e_data);
            check({tag, ".data_hold"}, bus.resp_data, e_data);
         end
      end
      check({tag, ".cerr"}, 32'(compat_error), 32'(model_cerr()));
   endtask

   initial begin
      logic [31:0] rd;
      int acks, sel, slot;
      logic wr;
      logic [19:0] addr;
      logic [31:0] wdata;

      rst_n = 1'b0;
      bus.req_wr = 1'b0; bus.req_rd = 1'b0; bus.req_addr = '0; bus.req_data = '0;
      for (int k = 0; k < 64; k++) flag_m[k] = 0;
      for (int k = 0; k < NCOMP; k++) begin
         cur_m[k] = $urandom; old_m[k] = $urandom; ts_m[k] = $urandom;
      end
      cur_m[0] = 32'h0100_0000; old_m[0] = 32'h0080_0000;
      cur_m[2] = 32'h0080_1000;
      apply_versions();

      repeat (3) @(posedge clk);
      #1;
      check("rst.ack", 32'(bus.resp_ack), 32'd0);
      check("rst.sts", 32'(bus.resp_status), 32'd0);
      check("rst.data", bus.resp_data, 32'd0);
      check("rst.cerr", 32'(compat_error), 32'd0);
      rst_n = 1'b1;

      run("slot2_cur", 1'b0, 20'(REG_BASE + 'h20), 32'd0, rd);
      check("slot2_cur.const", rd, 32'h0080_1000);
      run("slot7", 1'b0, 20'(REG_BASE + 'h70), 32'd0, rd);
      run("out_of_win", 1'b0, 20'(REG_BASE + 'h400), 32'd0, rd);
      run("below_win", 1'b0, 20'(REG_BASE - 4), 32'd0, rd);
      run("wr_cur", 1'b1, 20'(REG_BASE + 'h0), 32'h1234_5678, rd);

      run("chk_fail_wr", 1'b1, 20'(REG_BASE + 'hC), 32'h0180_0000, rd);
      run("chk_fail_rd", 1'b0, 20'(REG_BASE + 'hC), 32'd0, rd);
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
      check("chk_fail.const", rd, 32'h3);
      check("chk_fail.cerr_const", 32'(compat_error), 32'd1);
`else
      check("chk_fail.const", rd, 32'h0);
`endif
      run("chk_pass_wr", 1'b1, 20'(REG_BASE + 'hC), 32'h00C0_0000, rd);
      run("chk_pass_rd", 1'b0, 20'(REG_BASE + 'hC), 32'd0, rd);
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
      check("chk_pass.const", rd, 32'h1);
`endif
      check("chk_pass.cerr_const", 32'(compat_error), 32'd0);

      // Read followed immediately by a write: the write lands in DECODE and is dropped.
      bus.req_rd = 1'b1; bus.req_addr = 20'(REG_BASE + 'hC);
      @(posedge clk); #1;
      bus.req_rd = 1'b0; bus.req_wr = 1'b1; bus.req_data = 32'h0180_0000;
      @(posedge clk); #1;
      bus.req_wr = 1'b0;
      check("b2b.ack", 32'(bus.resp_ack), 32'd1);
`ifdef X4XX_VERSION_COMPAT_CHECK_EN
      check("b2b.data", bus.resp_data, 32'h1);
`else
      check("b2b.data", bus.resp_data, 32'h0);
`endif
      acks = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.resp_ack === 1'b1) acks++;
      end
      check("b2b.no_second_ack", 32'(acks), 32'd0);
      run("b2b.after", 1'b0, 20'(REG_BASE + 'hC), 32'd0, rd);

      // Reset while in DECODE abandons the request and clears the flags.
      run("pre_rst_fail", 1'b1, 20'(REG_BASE + 'hC), 32'h0180_0000, rd);
      bus.req_rd = 1'b1; bus.req_addr = 20'(REG_BASE + 'h20);
      @(posedge clk); #1;
      bus.req_rd = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst.cerr", 32'(compat_error), 32'd0);
      @(posedge clk); #1;
      check("mid_rst.ack", 32'(bus.resp_ack), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 64; k++) flag_m[k] = 0;
      run("post_rst", 1'b0, 20'(REG_BASE + 'hC), 32'd0, rd);
      check("post_rst.const", rd, 32'h0);

      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         wr = 1'($urandom_range(0, 1));
         if (sel == 0) begin
            addr = ($urandom_range(0, 1) == 0) ? 20'(REG_BASE - 4 * $urandom_range(1, 4))
                                               : 20'(REG_BASE + 'h400 + 4 * $urandom_range(0, 8));
         end else begin
            slot = (sel < 9) ? $urandom_range(0, NCOMP - 1) : $urandom_range(NCOMP, 63);
            addr = 20'(REG_BASE + 16 * slot + 4 * $urandom_range(0, 3));
         end
         slot = (int'(addr) - REG_BASE) / 16;
         if (slot < 0 || slot >= NCOMP) slot = 0;
         case ($urandom_range(0, 3))
            0: wdata = $urandom;
            1: wdata = old_m[slot];
            2: wdata = old_m[slot] - 32'd1;
            default: wdata = cur_m[slot];
         endcase
         run("rand", wr, addr, wdata, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

// File: doc/x4xx_version_table.md
X4XX_VERSION_TABLE -- requirements
Module: x4xx_version_table

Interface
REQ-001 SHALL have parameter REG_BASE, default 0, ctrlport byte base address of the 1 KiB window.
REQ-002 SHALL have parameter NUM_COMPONENTS, default 64, range 1..64, number of populated component slots.
REQ-003 SHALL have port s_ctrlport_clk  in  1  sole clock.
REQ-004 SHALL have port s_ctrlport_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports s_ctrlport_req_wr / s_ctrlport_req_rd  in  1 each  request strobes.
REQ-006 SHALL have ports s_ctrlport_req_addr  in  20 and s_ctrlport_req_data  in  32.
REQ-007 SHALL have ports s_ctrlport_resp_ack  out  1, s_ctrlport_resp_status  out  2 and s_ctrlport_resp_data  out  32.
REQ-008 SHALL have port version_info  in  NUM_COMPONENTS*96  per slot: [31:0] current, [63:32] oldest compatible, [95:64] timestamp.
REQ-009 SHALL have port compat_error  out  1  OR of all stored failure flags.

Function
REQ-010 SHALL decode slot k at REG_BASE+16k with offsets 0x0 CURRENT, 0x4 OLDEST_COMPATIBLE, 0x8 LAST_MODIFIED, 0xC COMPAT_CHECK.
REQ-011 SHALL use a three-state FSM (IDLE, DECODE, RESP); a request in IDLE -> DECODE (latch addr/data/type) -> RESP (drive response) -> IDLE.
REQ-012 SHALL assert resp_ack for exactly one cycle, two cycles after the request cycle, for every in-window address.
REQ-013 SHALL ignore requests arriving in DECODE or RESP; no response is generated for them.
REQ-014 SHALL never acknowledge out-of-window addresses; the FSM still passes through DECODE and returns to IDLE with ack low.
REQ-015 SHALL return OKAY with slot data for reads of offsets 0x0/0x4/0x8 on slots below NUM_COMPONENTS.
REQ-016 SHALL return CMDERR with data 0 for any access to slots NUM_COMPONENTS..63.
REQ-017 SHALL return CMDERR with data 0 for writes to offsets 0x0/0x4/0x8.
REQ-018 SHALL, on a COMPAT_CHECK write of SW version S, compute both flags from that slot's version_info:
- TOO_OLD = current[31:23] < S[31:23]
- TOO_NEW = S < oldest_compatible (32-bit unsigned compare)
- store {CHECKED=1, TOO_OLD, TOO_NEW}
- ack OKAY.
REQ-019 SHALL return {29'b0, TOO_NEW, TOO_OLD, CHECKED} at bits [2:0] on a COMPAT_CHECK read, OKAY; an unchecked slot reads 0.
REQ-020 SHALL overwrite a slot's flags on each COMPAT_CHECK write, so a passing check clears that slot's failure.
REQ-021 SHALL update compat_error in the RESP cycle of the write that changes the flags (registered output).
REQ-022 SHALL hold resp_data and resp_status at their last driven values while ack is low.

Reset
REQ-023 SHALL asynchronously reset the following on s_ctrlport_rst_n low:
- FSM to IDLE
- resp_ack 0, resp_status OKAY (0), resp_data 0
- all check flags 0, compat_error 0
REQ-024 SHALL abandon any in-flight request on reset with no ack, and operate normally from the first clock after deassertion.

Configuration
REQ-025 SHALL compile COMPAT_CHECK storage and compat_error logic only when X4XX_VERSION_COMPAT_CHECK_EN is defined.
REQ-026 SHALL behave as follows without X4XX_VERSION_COMPAT_CHECK_EN: 0xC reads 0 with OKAY, 0xC writes return CMDERR, compat_error is tied 0.

Structure
REQ-027 SHALL place in a shared package:
- VERSION/TIMESTAMP field widths and MAJOR range
- offset constants 0x0/0x4/0x8/0xC
- CTRL_STS codes
- FSM state encoding
- MAX_NUM_OF_COMPONENTS=64
REQ-028 SHALL isolate the compare in one sub-module, x4xx_version_compat_cmp (combinational, 32-bit inputs, 2 flags out).

Verification
REQ-029 SHALL cover: NUM_COMPONENTS=6, slot 2 current 0x00801000, read REG_BASE+0x20 at cycle N -> ack at N+2, data 0x00801000, OKAY.
REQ-030 SHALL cover: NUM_COMPONENTS=6, read REG_BASE+0x70 -> ack, CMDERR, data 0; read REG_BASE+0x400 -> no ack within 10 cycles.
REQ-031 SHALL cover: slot 0 current 0x01000000, oldest 0x00800000; write 0x01800000 to +0xC -> compat_error=1, read +0xC returns 0x3.
REQ-032 SHALL cover: then write 0x00C00000 -> read returns 0x1, compat_error=0.
REQ-033 SHALL cover: a read at N followed by a write at N+1 -> only the read is acked; the write has no effect.
REQ-034 SHALL cover: reset asserted in DECODE -> no ack; flags are 0; the next read is acked normally two cycles after its request.
